if_id_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage of the pipelined RISC-V core. It accepts fetched instruction/PC triples from fetch with a valid/ready handshake and buffers up to DEPTH of them. It presents them in order to decode, so a decode stall does not immediately freeze the PC. A flush input discards all buffered entries when a taken branch redirects the PC.

---
 rtl/if_id_queue.sv | 87 ++++++++
 tb/tb_if_id_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {inst, pc, pc_plus4} with flush.
// Optional IFID_BUBBLE_NOP_EN drives a canonical addi x0,x0,0 bubble on out_* while empty.
module if_id_queue #(
  parameter int unsigned width = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [width-1:0]         in_inst,
  input  logic [width-1:0]         in_pc,
  input  logic [width-1:0]         in_pc_plus4,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [width-1:0]         out_inst,
  output logic [width-1:0]         out_pc,
  output logic [width-1:0]         out_pc_plus4,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [width-1:0] inst;
    logic [width-1:0] pc;
    logic [width-1:0] pc_plus4;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Handshake flags come only from the registered occupancy.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= '{inst: in_inst, pc: in_pc, pc_plus4: in_pc_plus4};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; flush beats push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  always_comb begin
    head         = mem[rd_ptr];
    out_inst     = head.inst;
    out_pc       = head.pc;
    out_pc_plus4 = head.pc_plus4;
`ifdef IFID_BUBBLE_NOP_EN
    if (!out_valid) begin
      out_inst     = width'(32'h0000_0013);
      out_pc       = '0;
      out_pc_plus4 = '0;
    end
`endif
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed vector table, reset/flush sequences, random vs queue model.
module tb_if_id_queue;

  localparam int unsigned W = 32;
  localparam int unsigned D = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_inst;
  logic [W-1:0] in_pc;
  logic [W-1:0] in_pc_plus4;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_inst;
  logic [W-1:0] out_pc;
  logic [W-1:0] out_pc_plus4;
  logic         flush;
  logic [1:0]   count;

  int total = 0;
  int bad   = 0;

  if_id_queue #(.width(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_pc_plus4(in_pc_plus4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .flush(flush), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h0050_0093 + pc;
  endfunction

  // Drive one cycle of inputs, clock it, and land 1 time unit after the edge.
  task automatic step(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid    = iv;
    in_pc       = pc;
    in_inst     = inst_of(pc);
    in_pc_plus4 = pc + 32'd4;
    out_ready   = ordy;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    int          cnt;
    logic        ov;
    logic        ir;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic ordy,
                              input logic fl, input int cnt, input logic ov, input logic ir,
                              input string name);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ordy = ordy; v.fl = fl;
    v.cnt = cnt; v.ov = ov; v.ir = ir; v.name = name;
    return v;
  endfunction

  // Expected head PC for table rows, valid only where ov is set.
  logic [31:0] exp_head[$];

  task automatic check_state(input string tag, input int cnt, input logic ov, input logic ir,
                             input logic [31:0] hpc);
    chk({tag, ".count"},     32'(count),     32'(cnt));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    if (ov) begin
      chk({tag, ".out_pc"},    out_pc,       hpc);
      chk({tag, ".out_inst"},  out_inst,     inst_of(hpc));
      chk({tag, ".out_pc4"},   out_pc_plus4, hpc + 32'd4);
    end
`ifdef IFID_BUBBLE_NOP_EN
    else begin
      chk({tag, ".bubble_inst"}, out_inst, 32'h0000_0013);
      chk({tag, ".bubble_pc"},   out_pc,   32'h0);
    end
`endif
  endtask

  // Reference model: a plain FIFO of triples.
  typedef struct { logic [31:0] inst; logic [31:0] pc; logic [31:0] pc4; } trip_t;
  trip_t mq[$];

  initial begin
    in_valid = 1'b0; in_pc = '0; in_inst = '0; in_pc_plus4 = '0;
    out_ready = 1'b0; flush = 1'b0;
    rst = 1'b0;
    #12;
    check_state("reset", 0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_state("idle", 0, 1'b0, 1'b1, 32'h0);

    // Fill to full, reject when full, pop releases a slot, drain.
    vecs.push_back(mk(1, 32'h00, 0, 0, 1, 1, 1, "push0"));   exp_head.push_back(32'h00);
    vecs.push_back(mk(1, 32'h04, 0, 0, 2, 1, 0, "push4"));   exp_head.push_back(32'h00);
    vecs.push_back(mk(1, 32'h08, 0, 0, 2, 1, 0, "full"));    exp_head.push_back(32'h00);
    vecs.push_back(mk(1, 32'h08, 1, 0, 1, 1, 1, "popfull")); exp_head.push_back(32'h04);
    vecs.push_back(mk(1, 32'h08, 0, 0, 2, 1, 0, "push8"));   exp_head.push_back(32'h04);
    vecs.push_back(mk(0, 32'h00, 1, 0, 1, 1, 1, "drain1"));  exp_head.push_back(32'h08);
    vecs.push_back(mk(0, 32'h00, 1, 0, 0, 0, 1, "drain2"));  exp_head.push_back(32'h00);
    // Streaming: count holds at 1, head follows the pushed PC.
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1, 32'(i * 4), 1, 0, 1, 1, 1, "stream"));
      exp_head.push_back(32'(i * 4));
    end
    vecs.push_back(mk(0, 32'h00, 1, 0, 0, 0, 1, "sdrain"));  exp_head.push_back(32'h00);
    // Flush with full queue and a push/pop attempt.
    vecs.push_back(mk(1, 32'h10, 0, 0, 1, 1, 1, "fill1"));   exp_head.push_back(32'h10);
    vecs.push_back(mk(1, 32'h14, 0, 0, 2, 1, 0, "fill2"));   exp_head.push_back(32'h10);
    vecs.push_back(mk(1, 32'h40, 1, 1, 0, 0, 1, "flush"));   exp_head.push_back(32'h00);
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 0, 1, "postfl"));  exp_head.push_back(32'h00);
    vecs.push_back(mk(1, 32'h44, 0, 0, 1, 1, 1, "pushfl"));  exp_head.push_back(32'h44);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].iv, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
      check_state(vecs[i].name, vecs[i].cnt, vecs[i].ov, vecs[i].ir, exp_head[i]);
    end

    // Asynchronous reset mid-operation with count = 1.
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_state("async_rst", 0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 32'h80, 0, 0);
    check_state("rst_push", 1, 1'b1, 1'b1, 32'h80);
    step(0, 32'h00, 1, 0);
    check_state("rst_drain", 0, 1'b0, 1'b1, 32'h0);

    // Random traffic against the queue model.
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      logic iv, ordy, fl, m_ir, m_ov;
      trip_t t;
      m_ir = (mq.size() != D);
      m_ov = (mq.size() != 0);
      chk("rnd.count",     32'(count),     32'(mq.size()));
      chk("rnd.in_ready",  32'(in_ready),  32'(m_ir));
      chk("rnd.out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("rnd.out_inst", out_inst,     mq[0].inst);
        chk("rnd.out_pc",   out_pc,       mq[0].pc);
        chk("rnd.out_pc4",  out_pc_plus4, mq[0].pc4);
      end
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      t.inst = $urandom;
      t.pc   = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      t.pc4  = t.pc + 32'd4;
      in_valid = iv; in_inst = t.inst; in_pc = t.pc; in_pc_plus4 = t.pc4;
      out_ready = ordy; flush = fl;
      if (fl) begin
        mq.delete();
      end else begin
        if (m_ov && ordy) void'(mq.pop_front());
        if (m_ir && iv)   mq.push_back(t);
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
